// File: rtl/instr_encoder_tx.sv
// instr_encoder_tx: encodes one RV32I instruction per request and streams
// its 32-bit word out as four little-endian bytes over a valid/ready link.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   req_valid / req_ready      request handshake (ready only while idle)
//   fmt, funct3, alt           format select, funct3, funct7[5]
//   rd, rs1, rs2, imm          register fields and immediate
//   byte_valid / byte_ready    byte stream handshake
//   byte_data, byte_last       current byte, high on byte 3
//   err                        immediate range error from last acceptance
//
// Build option: define INSTR_ENC_CHECK_EN to enable the immediate range
// check; when undefined, err is tied low and the check logic is omitted.

module instr_encoder_tx (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  fmt,
    input  logic [2:0]  funct3,
    input  logic        alt,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [31:0] imm,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    input  logic        byte_ready,
    output logic        byte_last,
    output logic        err
);

    localparam logic [2:0] FMT_R      = 3'd0;
    localparam logic [2:0] FMT_I      = 3'd1;
    localparam logic [2:0] FMT_LOAD   = 3'd2;
    localparam logic [2:0] FMT_STORE  = 3'd3;
    localparam logic [2:0] FMT_BRANCH = 3'd4;
    localparam logic [2:0] FMT_LUI    = 3'd5;
    localparam logic [2:0] FMT_AUIPC  = 3'd6;
    localparam logic [2:0] FMT_JAL    = 3'd7;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [2:0] {
        S_IDLE,
        S_B0,
        S_B1,
        S_B2,
        S_B3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] word_q, word_d;
    logic [31:0] enc_word;
    logic        is_shift;
    logic        accept;
    logic        fire;

    assign is_shift = (funct3 == 3'b001) || (funct3 == 3'b101);
    assign accept   = req_valid && req_ready;
    assign fire     = byte_valid && byte_ready;

    // Instruction word builder
    always_comb begin
        enc_word = '0;
        case (fmt)
            FMT_R:
                enc_word = {1'b0, alt, 5'b0, rs2, rs1, funct3, rd, OP_R};
            FMT_I:
                if (is_shift)
                    enc_word = {1'b0, alt, 5'b0, imm[4:0],
                                rs1, funct3, rd, OP_I};
                else
                    enc_word = {imm[11:0], rs1, funct3, rd, OP_I};
            FMT_LOAD:
                enc_word = {imm[11:0], rs1, funct3, rd, OP_LOAD};
            FMT_STORE:
                enc_word = {imm[11:5], rs2, rs1, funct3,
                            imm[4:0], OP_STORE};
            FMT_BRANCH:
                enc_word = {imm[12], imm[10:5], rs2, rs1, funct3,
                            imm[4:1], imm[11], OP_BRANCH};
            FMT_LUI:
                enc_word = {imm[31:12], rd, OP_LUI};
            FMT_AUIPC:
                enc_word = {imm[31:12], rd, OP_AUIPC};
            FMT_JAL:
                enc_word = {imm[20], imm[10:1], imm[11], imm[19:12],
                            rd, OP_JAL};
            default:
                enc_word = '0;
        endcase
    end

    // State and word registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            word_q  <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    state_d = S_B0;
                    word_d  = enc_word;
                end
            end
            S_B0:    if (fire) state_d = S_B1;
            S_B1:    if (fire) state_d = S_B2;
            S_B2:    if (fire) state_d = S_B3;
            S_B3:    if (fire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs; req_ready also gated by rst_n so it reads 0 during reset
    always_comb begin
        req_ready  = rst_n && (state_q == S_IDLE);
        byte_valid = (state_q != S_IDLE);
        byte_last  = (state_q == S_B3);
        byte_data  = 8'h00;
        case (state_q)
            S_B0:    byte_data = word_q[7:0];
            S_B1:    byte_data = word_q[15:8];
            S_B2:    byte_data = word_q[23:16];
            S_B3:    byte_data = word_q[31:24];
            default: byte_data = 8'h00;
        endcase
    end

`ifdef INSTR_ENC_CHECK_EN
    logic err_q, err_d;
    logic chk_err;
    logic sext12, sext13, sext21;

    // Value fits in N signed bits when all bits above N-2 agree
    assign sext12 = (&imm[31:11]) || !(|imm[31:11]);
    assign sext13 = (&imm[31:12]) || !(|imm[31:12]);
    assign sext21 = (&imm[31:20]) || !(|imm[31:20]);

    always_comb begin
        chk_err = 1'b0;
        case (fmt)
            FMT_I:
                chk_err = is_shift ? (|imm[31:5]) : !sext12;
            FMT_LOAD,
            FMT_STORE:
                chk_err = !sext12;
            FMT_BRANCH:
                chk_err = !sext13 || imm[0];
            FMT_JAL:
                chk_err = !sext21 || imm[0];
            FMT_LUI,
            FMT_AUIPC:
                chk_err = |imm[11:0];
            default:
                chk_err = 1'b0;
        endcase
    end

    assign err_d = accept ? chk_err : err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= err_d;
    end

    assign err = err_q;
`else
    assign err = 1'b0;
`endif

endmodule

// File: tb/tb_instr_encoder_tx.sv
// tb_instr_encoder_tx: directed self-checking bench for instr_encoder_tx.
// Drives and samples on the falling edge; DUT state changes on rising.

module tb_instr_encoder_tx;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  fmt;
    logic [2:0]  funct3;
    logic        alt;
    logic [4:0]  rd, rs1, rs2;
    logic [31:0] imm;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        byte_ready;
    logic        byte_last;
    logic        err;

    int checks = 0;
    int errors = 0;

`ifdef INSTR_ENC_CHECK_EN
    localparam logic EXP_ERR = 1'b1;
`else
    localparam logic EXP_ERR = 1'b0;
`endif

    always #5 clk = ~clk;

    instr_encoder_tx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .fmt        (fmt),
        .funct3     (funct3),
        .alt        (alt),
        .rd         (rd),
        .rs1        (rs1),
        .rs2        (rs2),
        .imm        (imm),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .byte_last  (byte_last),
        .err        (err)
    );

    // Vector table: fmt, funct3, alt, rd, rs1, rs2, imm, expected word
    localparam int NV = 10;
    localparam logic [2:0]  V_FMT [NV] = '{0, 0, 1, 4, 3, 5, 7, 1, 6, 2};
    localparam logic [2:0]  V_F3  [NV] = '{0, 0, 0, 0, 2, 3, 0, 5, 0, 2};
    localparam logic        V_ALT [NV] = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0};
    localparam logic [4:0]  V_RD  [NV] = '{3, 3, 1, 31, 0, 5, 1, 1, 10, 6};
    localparam logic [4:0]  V_RS1 [NV] = '{1, 1, 0, 1, 2, 7, 0, 2, 0, 2};
    localparam logic [4:0]  V_RS2 [NV] = '{2, 2, 0, 2, 5, 0, 0, 0, 0, 0};
    localparam logic [31:0] V_IMM [NV] = '{
        32'h0, 32'h0, 32'hFFFF_FFFF, 32'h8, 32'hC,
        32'h1234_5000, 32'h8, 32'h3, 32'h0000_1000, 32'hFFFF_FFFC};
    localparam logic [31:0] V_EXP [NV] = '{
        32'h0020_81B3, 32'h4020_81B3, 32'hFFF0_0093, 32'h0020_8463,
        32'h0051_2623, 32'h1234_52B7, 32'h0080_00EF, 32'h4031_5093,
        32'h0000_1517, 32'hFFC1_2303};

    // Present a request for one edge; rdy is req_ready seen with it
    task automatic drive_req(input logic [2:0] f, input logic [2:0] f3,
                             input logic a, input logic [4:0] d,
                             input logic [4:0] s1, input logic [4:0] s2,
                             input logic [31:0] im, output logic rdy);
        fmt = f; funct3 = f3; alt = a;
        rd = d; rs1 = s1; rs2 = s2; imm = im;
        req_valid = 1'b1;
        rdy = req_ready;
        @(negedge clk);
        req_valid = 1'b0;
        imm = 32'hDEAD_BEEF;
        rd = 5'd17;
    endtask

    // Capture four consecutive byte cycles, then idle status
    task automatic recv(output logic [31:0] w, output logic [3:0] vm,
                        output logic [3:0] lm, output logic e0,
                        output logic idle);
        e0 = err;
        for (int k = 0; k < 4; k++) begin
            w[8*k +: 8] = byte_data;
            vm[k] = byte_valid;
            lm[k] = byte_last;
            @(negedge clk);
        end
        idle = req_ready && !byte_valid;
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if ({req_ready, byte_valid, byte_data, byte_last, err} !== 12'h0) begin
            errors++;
            $display("FAIL reset_outputs: got rdy=%b v=%b d=%h l=%b e=%b want all 0",
                     req_ready, byte_valid, byte_data, byte_last, err);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({req_ready, byte_valid} !== 2'b10) begin
            errors++;
            $display("FAIL reset_release: got rdy=%b v=%b want rdy=1 v=0",
                     req_ready, byte_valid);
        end
        @(negedge clk);
    endtask

    task automatic test_formats;
        logic        rdy, e0, idle;
        logic [31:0] w;
        logic [3:0]  vm, lm;
        for (int i = 0; i < NV; i++) begin
            drive_req(V_FMT[i], V_F3[i], V_ALT[i], V_RD[i],
                      V_RS1[i], V_RS2[i], V_IMM[i], rdy);
            recv(w, vm, lm, e0, idle);
            checks++;
            if (w !== V_EXP[i]) begin
                errors++;
                $display("FAIL fmt_word[%0d]: got %h want %h", i, w, V_EXP[i]);
            end
            checks++;
            if ({rdy, vm, lm, idle} !== {1'b1, 4'hF, 4'h8, 1'b1}) begin
                errors++;
                $display("FAIL fmt_hs[%0d]: got rdy=%b v=%b l=%b idle=%b want 1 1111 1000 1",
                         i, rdy, vm, lm, idle);
            end
            checks++;
            if (e0 !== 1'b0) begin
                errors++;
                $display("FAIL fmt_err[%0d]: got %b want 0", i, e0);
            end
        end
    endtask

    task automatic test_backpressure;
        logic rdy;
        drive_req(3'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'h0, rdy);
        checks++;
        if ({byte_valid, byte_data} !== {1'b1, 8'hB3}) begin
            errors++;
            $display("FAIL bp_b0: got v=%b d=%h want 1 b3", byte_valid, byte_data);
        end
        @(negedge clk);
        byte_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            req_valid = (i != 1);
            fmt = 3'd5;
            imm = 32'hFFFF_F000;
            @(negedge clk);
            checks++;
            if ({byte_valid, byte_data, byte_last, req_ready} !==
                {1'b1, 8'h81, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h l=%b rdy=%b want 1 81 0 0",
                         i, byte_valid, byte_data, byte_last, req_ready);
            end
        end
        req_valid = 1'b0;
        byte_ready = 1'b1;
        @(negedge clk);
        checks++;
        if ({byte_valid, byte_data, byte_last} !== {1'b1, 8'h20, 1'b0}) begin
            errors++;
            $display("FAIL bp_b2: got v=%b d=%h l=%b want 1 20 0",
                     byte_valid, byte_data, byte_last);
        end
        @(negedge clk);
        checks++;
        if ({byte_valid, byte_data, byte_last} !== {1'b1, 8'h00, 1'b1}) begin
            errors++;
            $display("FAIL bp_b3: got v=%b d=%h l=%b want 1 00 1",
                     byte_valid, byte_data, byte_last);
        end
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({req_ready, byte_valid} !== 2'b10) begin
            errors++;
            $display("FAIL bp_no_accept: got rdy=%b v=%b want 1 0",
                     req_ready, byte_valid);
        end
    endtask

    task automatic test_reset_mid;
        logic        rdy, e0, idle;
        logic [31:0] w;
        logic [3:0]  vm, lm;
        drive_req(3'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'h0, rdy);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({byte_valid, byte_data} !== {1'b1, 8'h20}) begin
            errors++;
            $display("FAIL rstmid_b2: got v=%b d=%h want 1 20", byte_valid, byte_data);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({req_ready, byte_valid, byte_data, byte_last, err} !== 12'h0) begin
            errors++;
            $display("FAIL rstmid_async: got rdy=%b v=%b d=%h l=%b e=%b want all 0",
                     req_ready, byte_valid, byte_data, byte_last, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checks++;
        if ({req_ready, byte_valid} !== 2'b10) begin
            errors++;
            $display("FAIL rstmid_release: got rdy=%b v=%b want 1 0",
                     req_ready, byte_valid);
        end
        drive_req(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'h8, rdy);
        recv(w, vm, lm, e0, idle);
        checks++;
        if (w !== 32'h0020_8463) begin
            errors++;
            $display("FAIL rstmid_word: got %h want 00208463", w);
        end
        checks++;
        if ({rdy, vm, lm, idle} !== {1'b1, 4'hF, 4'h8, 1'b1}) begin
            errors++;
            $display("FAIL rstmid_hs: got rdy=%b v=%b l=%b idle=%b want 1 1111 1000 1",
                     rdy, vm, lm, idle);
        end
    endtask

    task automatic test_err;
        logic        rdy, e0, idle;
        logic [31:0] w;
        logic [3:0]  vm, lm;
        drive_req(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'h7, rdy);
        recv(w, vm, lm, e0, idle);
        checks++;
        if (w !== 32'h0020_8363) begin
            errors++;
            $display("FAIL err_br_word: got %h want 00208363", w);
        end
        checks++;
        if ({e0, err} !== {EXP_ERR, EXP_ERR}) begin
            errors++;
            $display("FAIL err_br_flag: got b0=%b idle=%b want %b",
                     e0, err, EXP_ERR);
        end
        drive_req(3'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h800, rdy);
        recv(w, vm, lm, e0, idle);
        checks++;
        if (w !== 32'h8000_0093) begin
            errors++;
            $display("FAIL err_addi_word: got %h want 80000093", w);
        end
        checks++;
        if (e0 !== EXP_ERR) begin
            errors++;
            $display("FAIL err_addi_flag: got %b want %b", e0, EXP_ERR);
        end
        drive_req(3'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'h8, rdy);
        recv(w, vm, lm, e0, idle);
        checks++;
        if ({w, e0, err} !== {32'h0020_8463, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL err_clear: got w=%h b0=%b idle=%b want 00208463 0 0",
                     w, e0, err);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = 1'b0;
        byte_ready = 1'b1;
        fmt = '0; funct3 = '0; alt = 1'b0;
        rd = '0; rs1 = '0; rs2 = '0; imm = '0;
        test_reset;
        test_formats;
        test_backpressure;
        test_reset_mid;
        test_err;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
